fetch_unit: RTL and testbench

//   Instruction-fetch stage of the RISC-V core. Owns the PC, issues word reads to instruction memory
//   and buffers returned words in a small FIFO. Hands {pc, instr} to decode over valid/ready.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional perf counters in fetch_unit are enabled by FETCH_PERF_EN.
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear, shared by the output buffer
// and the in-flight PC queue. Clear wins over push/pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = fetch_entry_t,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clear,
   input  logic          i_push,
   input  T              i_data,
   input  logic          i_pop,
   output T              o_data,
   output logic [CW-1:0] o_count,
   output logic          o_empty,
   output logic          o_full
);

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign o_empty = (count == '0);
   assign o_full  = (count == CW'(DEPTH));
   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);
   assign o_data  = mem[rd_ptr];
   assign o_count = count;

   // pointers and occupancy
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // payload storage, no reset needed
   always_ff @(posedge i_clk) begin
      if (do_push && !i_clear) mem[wr_ptr] <= i_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, output FIFO.
// Define FETCH_PERF_EN to add o_stall_cnt / o_flush_cnt counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic            o_imem_req_valid,
   output logic [XLEN-1:0] o_imem_req_addr,
   input  logic            i_imem_req_ready,
   input  logic            i_imem_rsp_valid,
   input  logic [XLEN-1:0] i_imem_rsp_data,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_instr_valid,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_pc,
   input  logic            i_instr_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     o_stall_cnt,
   output logic [31:0]     o_flush_cnt
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e    state;
   fetch_state_e    state_next;
   logic [XLEN-1:0] pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   out_next;
   logic            credit;
   logic            req_fire;
   logic            rsp_take;
   logic            rsp_push;
   logic            pop;

   fetch_entry_t    buf_head;
   fetch_entry_t    buf_in;
   logic [CW-1:0]   buf_count;
   logic            buf_empty;
   logic            buf_full;

   logic [XLEN-1:0] pcq_head;
   logic [CW-1:0]   pcq_count;
   logic            pcq_empty;
   logic            pcq_full;

   logic            unused;

   assign credit   = ({1'b0, outstanding} + {1'b0, buf_count})
                     < (CW + 1)'(FIFO_DEPTH);
   assign req_fire = o_imem_req_valid && i_imem_req_ready;
   assign rsp_take = i_imem_rsp_valid && (outstanding != '0);
   assign rsp_push = rsp_take && (state == RUN) && !i_redirect
                     && !pcq_empty;
   assign out_next = outstanding + CW'(req_fire) - CW'(rsp_take);
   assign pop      = o_instr_valid && i_instr_ready;
   assign buf_in   = '{pc: pcq_head, instr: i_imem_rsp_data};
   assign unused   = ^{pcq_count, pcq_full, buf_full, i_redirect_pc[1:0]};

   // state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= RUN;
      else       state <= state_next;
   end

   // next-state: flush until every stale response has drained
   always_comb begin
      state_next = state;
      unique case (state)
         RUN: begin
            if (i_redirect && (out_next != '0)) state_next = FLUSH;
         end
         FLUSH: begin
            if (!i_redirect && (outstanding == '0)) state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   // outputs: request gating and decode-facing head view
   always_comb begin
      o_imem_req_valid = !i_rst && (state == RUN) && !i_redirect && credit;
      o_imem_req_addr  = pc;
      o_instr_valid    = !buf_empty && !i_redirect;
      o_instr          = o_instr_valid ? buf_head.instr : NOP_INSTR;
      o_pc             = o_instr_valid ? buf_head.pc : '0;
   end

   // PC and in-flight request count
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc          <= RESET_PC;
         outstanding <= '0;
      end else begin
         outstanding <= out_next;
         if (i_redirect)    pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
         else if (req_fire) pc <= pc + XLEN'(4);
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (fetch_entry_t)
   ) u_buf (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (i_redirect),
      .i_push  (rsp_push),
      .i_data  (buf_in),
      .i_pop   (pop),
      .o_data  (buf_head),
      .o_count (buf_count),
      .o_empty (buf_empty),
      .o_full  (buf_full)
   );

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (logic [XLEN-1:0])
   ) u_pcq (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (i_redirect),
      .i_push  (req_fire),
      .i_data  (pc),
      .i_pop   (rsp_push),
      .o_data  (pcq_head),
      .o_count (pcq_count),
      .o_empty (pcq_empty),
      .o_full  (pcq_full)
   );

`ifdef FETCH_PERF_EN
   // saturating stall and redirect counters
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if ((state == RUN) && buf_empty && (o_stall_cnt != '1))
            o_stall_cnt <= o_stall_cnt + 32'd1;
         if (i_redirect && (o_flush_cnt != '1))
            o_flush_cnt <= o_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table after reset plus
// stall, redirect, random-memory and wrap sequences.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_ready;

   logic        w_rst;
   logic        w_req_valid;
   logic [31:0] w_req_addr;
   logic        w_req_ready;
   logic        w_instr_valid;
   logic [31:0] w_instr;
   logic [31:0] w_pc;

`ifdef FETCH_PERF_EN
   logic [31:0] stall_cnt, flush_cnt, w_stall_cnt, w_flush_cnt;
`endif

   always #5 clk = ~clk;

   fetch_unit u_dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .o_imem_req_valid (req_valid),
      .o_imem_req_addr  (req_addr),
      .i_imem_req_ready (req_ready),
      .i_imem_rsp_valid (rsp_valid),
      .i_imem_rsp_data  (rsp_data),
      .i_redirect       (redirect),
      .i_redirect_pc    (redirect_pc),
      .o_instr_valid    (instr_valid),
      .o_instr          (instr),
      .o_pc             (pc),
      .i_instr_ready    (instr_ready)
`ifdef FETCH_PERF_EN
      ,
      .o_stall_cnt      (stall_cnt),
      .o_flush_cnt      (flush_cnt)
`endif
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .i_clk            (clk),
      .i_rst            (w_rst),
      .o_imem_req_valid (w_req_valid),
      .o_imem_req_addr  (w_req_addr),
      .i_imem_req_ready (w_req_ready),
      .i_imem_rsp_valid (1'b0),
      .i_imem_rsp_data  (32'h0),
      .i_redirect       (1'b0),
      .i_redirect_pc    (32'h0),
      .o_instr_valid    (w_instr_valid),
      .o_instr          (w_instr),
      .o_pc             (w_pc),
      .i_instr_ready    (1'b1)
`ifdef FETCH_PERF_EN
      ,
      .o_stall_cnt      (w_stall_cnt),
      .o_flush_cnt      (w_flush_cnt)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      logic        rv;
      logic [31:0] addr;
      logic        iv;
      logic [31:0] ipc;
   } vec_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   pend_t       pend[$];
   vec_t        tbl[7];
   int          errors = 0;
   int          checks = 0;
   int          cyc_n = 0;
   int          last_due = 0;
   int          dmin = 1;
   int          dmax = 1;
   int          rdy_pct = 100;
   int          dec_pct = 100;
   int          consumed = 0;
   logic [31:0] exp_pc;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return ~a ^ 32'h3C5A_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc_n);
      end
   endtask

   // drive memory/decode inputs for this cycle, then let logic settle
   task automatic pre();
      req_ready   = ($urandom_range(99) < rdy_pct);
      instr_ready = ($urandom_range(99) < dec_pct);
      if (pend.size() > 0 && pend[0].due <= cyc_n) begin
         rsp_valid = 1'b1;
         rsp_data  = mdata(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = 32'hDEAD_BEEF;
      end
      #1;
   endtask

   // record accepted request, score consumed word, advance a cycle
   task automatic post();
      int d;
      int due;
      if (req_valid && req_ready) begin
         d   = $urandom_range(dmax, dmin);
         due = cyc_n + d;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend.push_back('{req_addr, due});
      end
      if (instr_valid && instr_ready) begin
         chk("sb_pc", pc, exp_pc);
         chk("sb_instr", instr, mdata(exp_pc));
         exp_pc = exp_pc + 32'd4;
         consumed++;
      end
      if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic tick();
      pre();
      post();
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      redirect = 1'b0;
      #1;
      chk("rst_ivalid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr, NOP);
      chk("rst_pc", pc, 32'd0);
      chk("rst_rvalid", {31'b0, req_valid}, 32'd0);
      pend.delete();
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b0;
      cyc_n   += 2;
      last_due = cyc_n;
      exp_pc   = 32'd0;
   endtask

   task automatic run_until(input int target, input int budget,
                            input string name);
      int start;
      int n;
      start = consumed;
      n     = 0;
      while (consumed < start + target && n < budget) begin
         tick();
         n++;
      end
      chk(name, {31'b0, consumed >= start + target}, 32'd1);
   endtask

   initial begin
      tbl[0] = '{1'b1, 32'h00, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 32'h04, 1'b0, 32'h0};
      tbl[2] = '{1'b0, 32'h08, 1'b1, 32'h0};
      tbl[3] = '{1'b1, 32'h08, 1'b1, 32'h4};
      tbl[4] = '{1'b1, 32'h0C, 1'b0, 32'h0};
      tbl[5] = '{1'b0, 32'h10, 1'b1, 32'h8};
      tbl[6] = '{1'b1, 32'h10, 1'b1, 32'hC};

      rst         = 1'b1;
      w_rst       = 1'b1;
      w_req_ready = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      req_ready   = 1'b1;
      rsp_valid   = 1'b0;
      rsp_data    = 32'h0;
      instr_ready = 1'b1;
      exp_pc      = 32'h0;
      @(negedge clk);

      // wrap instance: addresses F8, FC, then 0 once credit runs out
      w_rst = 1'b0;
      #1;
      chk("wrap_a0", w_req_addr, 32'hFFFF_FFF8);
      chk("wrap_v0", {31'b0, w_req_valid}, 32'd1);
      @(negedge clk);
      #1;
      chk("wrap_a1", w_req_addr, 32'hFFFF_FFFC);
      chk("wrap_v1", {31'b0, w_req_valid}, 32'd1);
      @(negedge clk);
      #1;
      chk("wrap_a2", w_req_addr, 32'h0000_0000);
      chk("wrap_v2", {31'b0, w_req_valid}, 32'd0);
      chk("wrap_iv", {31'b0, w_instr_valid}, 32'd0);
      chk("wrap_nop", w_instr, NOP);
      chk("wrap_pc", w_pc, 32'd0);
      @(negedge clk);

      // startup cycle table, 1-cycle memory
      do_reset();
      for (int i = 0; i < 7; i++) begin
         pre();
         chk($sformatf("t%0d_rv", i), {31'b0, req_valid},
             {31'b0, tbl[i].rv});
         chk($sformatf("t%0d_addr", i), req_addr, tbl[i].addr);
         chk($sformatf("t%0d_iv", i), {31'b0, instr_valid},
             {31'b0, tbl[i].iv});
         chk($sformatf("t%0d_pc", i), pc, tbl[i].ipc);
         chk($sformatf("t%0d_instr", i), instr,
             tbl[i].iv ? mdata(tbl[i].ipc) : NOP);
         post();
      end

      // decode stall: buffer fills, requests stop, nothing lost
      dec_pct = 0;
      for (int i = 0; i < 10; i++) tick();
      pre();
      chk("stall_rv", {31'b0, req_valid}, 32'd0);
      chk("stall_iv", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc", pc, exp_pc);
      post();
      dec_pct = 100;
      run_until(6, 40, "stall_resume");

      // redirect with two requests in flight
      do_reset();
      dmin = 3;
      dmax = 3;
      tick();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      pre();
      chk("rd3_iv", {31'b0, instr_valid}, 32'd0);
      chk("rd3_rv", {31'b0, req_valid}, 32'd0);
      post();
      redirect = 1'b0;
      chk("rd3_exp", exp_pc, 32'h0000_0100);
      run_until(3, 60, "rd3_progress");

      // redirect coinciding with response and pop
      do_reset();
      dmin = 1;
      dmax = 1;
      tick();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      pre();
      chk("rd4_rsp", {31'b0, rsp_valid}, 32'd1);
      chk("rd4_iv", {31'b0, instr_valid}, 32'd0);
      chk("rd4_pc", pc, 32'd0);
      chk("rd4_instr", instr, NOP);
      post();
      redirect = 1'b0;
      run_until(4, 40, "rd4_progress");

      // random memory and decode, starting across the PC wrap
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect = 1'b0;
      dmin     = 1;
      dmax     = 3;
      rdy_pct  = 70;
      dec_pct  = 80;
      run_until(1000, 20000, "rand_progress");

      // reset mid-stream clears outputs immediately
      do_reset();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
